mem_access_sequencer: RTL and testbench

//  Load/store sequencer in front of the 256-byte memory's byte-wide data port. Accepts one 8/16/32-bit

---
 rtl/feather_mem_pkg.sv | 48 ++++
 rtl/mem_access_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feather_mem_pkg.sv
// Shared types and helpers for the byte-serial load/store path.
// Contents:
//   size_e        access size encoding (byte, half, word, reserved)
//   seq_state_e   sequencer FSM states
//   last_index    index of the final byte of an access of the given size
//   extend_load   sign/zero extension of an assembled little-endian load
package feather_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'd0,
    SIZE_H    = 2'd1,
    SIZE_W    = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } seq_state_e;

  // The reserved size maps to 3 only so the result is defined.
  // Requests of that size fault before any byte is touched.
  function automatic logic [1:0] last_index(input size_e size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Byte and half loads extend from bit 7 or bit 15.
  // Sign extension is the default; is_unsigned selects zero extension.
  // Word loads pass through unchanged.
  function automatic logic [31:0] extend_load(input size_e       size,
                                              input logic        is_unsigned,
                                              input logic [31:0] data);
    case (size)
      SIZE_B:  return is_unsigned ? {24'h000000, data[7:0]}
                                  : {{24{data[7]}}, data[7:0]};
      SIZE_H:  return is_unsigned ? {16'h0000, data[15:0]}
                                  : {{16{data[15]}}, data[15:0]};
      SIZE_W:  return data;
      default: return 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer in front of a byte-wide memory port.
// It takes one 8/16/32-bit little-endian request per handshake.
// Each request is split into 1/2/4 consecutive byte accesses, one byte per cycle.
// The result is returned on a response handshake: loads are sign- or zero-extended,
// stores return 0, and faulting requests return 0 with rsp_error_o set.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid_i / req_ready_o        request handshake (ready only when idle)
//   req_addr_i, req_we_i, req_size_i request address, direction, size
//   req_unsigned_i, req_wdata_i      load extension mode, store data (LSB first)
//   rsp_valid_o / rsp_ready_i        response handshake
//   rsp_rdata_o, rsp_error_o         extended load data, fault flag
//   mem_address_o, mem_write_enable_o, mem_write_data_o   byte port to the memory
//   mem_data_i                       combinational read data for mem_address_o
module mem_access_sequencer
  import feather_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_write_enable_o,
  output logic [7:0]        mem_write_data_o,
  input  logic [7:0]        mem_data_i
);

  localparam logic [ADDR_W:0]   MEM_END  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  seq_state_e        r_state;
  size_e             r_size;
  logic              r_we;
  logic              r_uns;
  logic [31:0]       r_wdata;
  logic [31:0]       r_acc;
  logic [1:0]        r_idx;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_error;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;

  size_e             w_req_size;
  logic [ADDR_W:0]   w_req_end;
  logic              w_fault;
  logic              w_accept;
  logic [1:0]        w_last_idx;
  logic [1:0]        w_idx_next;
  logic [31:0]       w_acc_next;

  // The end address is computed one bit wider than the address.
  // An access that wraps past the top of the address space therefore lands above MEM_END and faults.
  assign w_req_size = size_e'(req_size_i);
  assign w_req_end  = {1'b0, req_addr_i} + {{(ADDR_W-1){1'b0}}, last_index(w_req_size)};
  assign w_fault    = (w_req_size == SIZE_RSVD) || (w_req_end >= MEM_END);
  assign w_accept   = req_valid_i && r_req_ready;
  assign w_last_idx = last_index(r_size);
  assign w_idx_next = r_idx + 2'd1;

  // The accumulator with the byte currently on mem_data_i merged in.
  // The last byte of a load is never stored separately; it is folded in here when the response is built.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 3'b000} +: 8] = mem_data_i;
  end

  // The sequencer FSM.
  // The memory port outputs always describe the byte being accessed in the current cycle.
  // On the edge that leaves a byte, they are reloaded for the next byte.
  // When the access finishes, they are cleared to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size      <= SIZE_B;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_wdata     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_size      <= w_req_size;
            r_we        <= req_we_i;
            r_uns       <= req_unsigned_i;
            r_wdata     <= req_wdata_i;
            r_acc       <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= ACCESS;
              r_mem_addr  <= req_addr_i;
              r_mem_we    <= req_we_i;
              r_mem_wdata <= req_we_i ? req_wdata_i[7:0] : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (!r_we) begin
            r_acc <= w_acc_next;
          end
          if (r_idx == w_last_idx) begin
            r_state     <= RESP;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= r_we ? 32'h00000000 : extend_load(r_size, r_uns, w_acc_next);
          end else begin
            r_idx       <= w_idx_next;
            r_mem_addr  <= r_mem_addr + ADDR_ONE;
            r_mem_wdata <= r_we ? r_wdata[{w_idx_next, 3'b000} +: 8] : 8'h00;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
          r_mem_addr  <= '0;
          r_mem_we    <= 1'b0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

  assign req_ready_o        = r_req_ready;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_rdata_o        = r_rsp_rdata;
  assign rsp_error_o        = r_rsp_error;
  assign mem_address_o      = r_mem_addr;
  assign mem_write_enable_o = r_mem_we;
  assign mem_write_data_o   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer.
// It includes a 256-byte memory model on the byte port.
// Expected responses are queued when a request is driven and compared when the response appears.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic [31:0] mem_address_o;
  logic        mem_write_enable_o;
  logic [7:0]  mem_write_data_o;
  logic [7:0]  mem_data_i;

  logic [7:0]  mem [0:255] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  bit weSeen = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mem_access_sequencer #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_we_i(req_we_i),
    .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .mem_address_o(mem_address_o),
    .mem_write_enable_o(mem_write_enable_o),
    .mem_write_data_o(mem_write_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read and a write on the rising edge.
  // Any write strobe is also recorded so the fault tests can prove the memory was never touched.
  assign mem_data_i = mem[mem_address_o[7:0]];

  always @(posedge clk) begin
    if (mem_write_enable_o) begin
      mem[mem_address_o[7:0]] <= mem_write_data_o;
      weSeen = 1'b1;
    end
  end

  // Drives one request and waits for the response, returning what was observed.
  // Latency is the number of rising edges, counting the accept edge, until rsp_valid_o is seen.
  // After acceptance the request inputs are scrambled to confirm the sequencer ignores them.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input bit autoAck,
                               output int lat, output logic [31:0] rd, output logic err);
    int guard;
    lat = -1;
    rd = 'x;
    err = 1'bx;
    @(negedge clk);
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready_o=%0b after %0d cycles, required 1", req_ready_o, guard);
      return;
    end
    req_valid_i = 1'b1;
    req_addr_i = addr;
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_wdata_i = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        req_valid_i = 1'b0;
        req_addr_i = 32'hFFFF_FFFF;
        req_we_i = ~we;
        req_size_i = 2'd3;
        req_unsigned_i = ~uns;
        req_wdata_i = 32'h5A5A_5A5A;
      end
      lat++;
    end while (!rsp_valid_o && lat < 20);
    if (!rsp_valid_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid_o=0 after %0d cycles, required 1", lat);
      return;
    end
    rd = rsp_rdata_o;
    err = rsp_error_o;
    if (autoAck) begin
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_rsp: ready/valid/err/rdata=%b/%b/%b/%h, required 1/0/0/00000000",
               req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o);
    end
    checks++;
    if ({mem_address_o, mem_write_enable_o, mem_write_data_o} !== 41'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: addr/we/wdata=%h/%b/%h, required 0/0/0",
               mem_address_o, mem_write_enable_o, mem_write_data_o);
    end
  endtask

  task automatic test_word_store_load();
    int lat;
    logic [31:0] rd;
    logic err;
    exp_t e;
    sb.push_back('{32'h0, 1'b0, 5});
    applyStimulus(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL word_store_rsp: rdata=%h err=%b lat=%0d, required %h/%b/%0d", rd, err, lat, e.rdata, e.err, e.lat);
    end
    checks++;
    if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL word_store_mem: mem[13..10]=%h%h%h%h, required deadbeef", mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]);
    end
    sb.push_back('{32'hDEADBEEF, 1'b0, 5});
    applyStimulus(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL word_load: rdata=%h err=%b lat=%0d, required %h/%b/%0d", rd, err, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_byte_half_loads();
    logic [31:0] addrs [5] = '{32'h20, 32'h31, 32'h20, 32'h20, 32'h31};
    logic        wes   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sizes [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    logic        unss  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] wdats [5] = '{32'h1111_1180, 32'h7777_9234, 32'h0, 32'h0, 32'h0};
    logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234};
    int          lats  [5] = '{2, 3, 2, 2, 3};
    int lat;
    logic [31:0] rd;
    logic err;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{exps[i], 1'b0, lats[i]});
      applyStimulus(addrs[i], wes[i], sizes[i], unss[i], wdats[i], 1'b1, lat, rd, err);
      e = sb.pop_front();
      checks++;
      if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
        errors++;
        $display("[TB] FAIL byte_half_%0d: rdata=%h err=%b lat=%0d, required %h/%b/%0d", i, rd, err, lat, e.rdata, e.err, e.lat);
      end
    end
    checks++;
    if ({mem[8'h32], mem[8'h31], mem[8'h21]} !== 24'h923400) begin
      errors++;
      $display("[TB] FAIL half_store_mem: mem[32,31,21]=%h,%h,%h, required 92,34,00", mem[8'h32], mem[8'h31], mem[8'h21]);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4] = '{32'hFD, 32'h0, 32'hFFFF_FFFE, 32'h100};
    logic        wes   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  sizes [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
    int lat;
    logic [31:0] rd;
    logic err;
    exp_t e;
    weSeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h0, 1'b1, 1});
      applyStimulus(addrs[i], wes[i], sizes[i], 1'b0, 32'hCAFE_F00D, 1'b1, lat, rd, err);
      e = sb.pop_front();
      checks++;
      if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
        errors++;
        $display("[TB] FAIL fault_%0d: rdata=%h err=%b lat=%0d, required %h/%b/%0d", i, rd, err, lat, e.rdata, e.err, e.lat);
      end
    end
    checks++;
    if (weSeen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_no_write: write strobe seen=%b, required 0", weSeen);
    end
    sb.push_back('{32'h0, 1'b0, 5});
    applyStimulus(32'hFC, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 1'b1, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat || mem[8'hFF] !== 8'h12) begin
      errors++;
      $display("[TB] FAIL top_word_store: rdata=%h err=%b lat=%0d mem[ff]=%h, required %h/%b/%0d/12",
               rd, err, lat, mem[8'hFF], e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] rd;
    logic err;
    exp_t e;
    sb.push_back('{32'h0000_BEEF, 1'b0, 3});
    applyStimulus(32'h10, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL stall_rsp: rdata=%h err=%b lat=%0d, required %h/%b/%0d", rd, err, lat, e.rdata, e.err, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_error_o} !== {1'b1, 1'b0, e.rdata, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: valid/ready/rdata/err=%b/%b/%h/%b, required 1/0/%h/0",
                 c, rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_error_o, e.rdata);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stall_release: valid/ready=%b/%b, required 0/1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset_mid_store();
    int lat;
    logic [31:0] rd;
    logic err;
    exp_t e;
    sb.push_back('{32'h0, 1'b0, 5});
    applyStimulus(32'h40, 1'b1, 2'd2, 1'b0, 32'h1111_1111, 1'b1, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL prefill_store: rdata=%h err=%b lat=%0d, required %h/%b/%0d", rd, err, lat, e.rdata, e.err, e.lat);
    end
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i = 32'h40;
    req_we_i = 1'b1;
    req_size_i = 2'd2;
    req_wdata_i = 32'hAABB_CCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, mem_address_o, mem_write_enable_o, mem_write_data_o}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: ready/valid/err/rdata/addr/we/wdata=%b/%b/%b/%h/%h/%b/%h, required 1/0/0/0/0/0/0",
               req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, mem_address_o, mem_write_enable_o, mem_write_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 32'h1111_CCDD) begin
      errors++;
      $display("[TB] FAIL mid_reset_mem: mem[43..40]=%h%h%h%h, required 1111ccdd", mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]);
    end
    sb.push_back('{32'h0000_00CC, 1'b0, 2});
    applyStimulus(32'h41, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, lat, rd, err);
    e = sb.pop_front();
    checks++;
    if ({rd, err} !== {e.rdata, e.err} || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL after_reset_load: rdata=%h err=%b lat=%0d, required %h/%b/%0d", rd, err, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrList [2] = '{32'h10, 32'hFC};
    logic [31:0] dataList [2] = '{32'hDEAD_BEEF, 32'h1234_5678};
    int accTimes[$];
    int got = 0;
    exp_t e;
    rsp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_unexpected: rdata=%h with no request outstanding, required none", rsp_rdata_o);
        end else begin
          e = sb.pop_front();
          if ({rsp_rdata_o, rsp_error_o} !== {e.rdata, e.err}) begin
            errors++;
            $display("[TB] FAIL b2b_rsp_%0d: rdata=%h err=%b, required %h/%b", got, rsp_rdata_o, rsp_error_o, e.rdata, e.err);
          end
        end
        got++;
      end
      req_valid_i = (accTimes.size() < 2);
      if (req_valid_i) begin
        req_addr_i = addrList[accTimes.size()];
        req_we_i = 1'b0;
        req_size_i = 2'd2;
        req_unsigned_i = 1'b0;
        if (req_ready_o) begin
          sb.push_back('{dataList[accTimes.size()], 1'b0, 5});
          accTimes.push_back(cyc);
        end
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    checks++;
    if (got != 2 || accTimes.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: responses=%0d accepts=%0d, required 2/2", got, accTimes.size());
    end else if (accTimes[1] - accTimes[0] != 6) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: %0d cycles between accepts, required 6", accTimes[1] - accTimes[0]);
    end
  endtask

  // Global watchdog so the bench always ends even if a wait is missed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  // Reset is checked while still asserted and then released on a falling edge.
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word_store_load();
    test_byte_half_loads();
    test_faults();
    test_stall();
    test_reset_mid_store();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
